// File: rtl/axil_regfile.sv
// AXI-lite slave exposing 2**REG_ADDR_WIDTH DATA_WIDTH-bit registers.
// AW and W are captured independently; the write commits when both are present.
module axil_regfile #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int LSB  = $clog2(STRB_WIDTH);
  localparam int NREG = 2 ** REG_ADDR_WIDTH;
  localparam int TOP  = LSB + REG_ADDR_WIDTH;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a >> TOP) == {ADDR_WIDTH{1'b0}};
  endfunction

  function automatic logic [REG_ADDR_WIDTH-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[LSB +: REG_ADDR_WIDTH];
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [DATA_WIDTH-1:0] regs_d [NREG];
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s, wr_ok_s, rd_ok_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s, wr_word_s;
  logic [STRB_WIDTH-1:0] wr_strb_s;
  logic                  prot_unused;

  assign prot_unused    = ^{s_axil_awprot, s_axil_arprot};
  // Ready terms are gated by rst so they read low throughout reset.
  assign s_axil_awready = rst & ~aw_held_q & ~bvalid_q;
  assign s_axil_wready  = rst & ~w_held_q & ~bvalid_q;
  assign s_axil_arready = rst & ~rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

  // Next-state logic for the write and read channels and the register array.
  always_comb begin
    aw_hs_s   = s_axil_awvalid & s_axil_awready;
    w_hs_s    = s_axil_wvalid & s_axil_wready;
    ar_hs_s   = s_axil_arvalid & s_axil_arready;
    wr_addr_s = aw_held_q ? awaddr_q : s_axil_awaddr;
    wr_data_s = w_held_q ? wdata_q : s_axil_wdata;
    wr_strb_s = w_held_q ? wstrb_q : s_axil_wstrb;
    // Commit only on the edge that completes the AW/W pair.
    commit_s  = (aw_held_q | aw_hs_s) & (w_held_q | w_hs_s) & (aw_hs_s | w_hs_s);
    wr_ok_s   = addr_ok(wr_addr_s);
    rd_ok_s   = addr_ok(s_axil_araddr);

    wr_word_s = regs_q[addr_idx(wr_addr_s)];
    for (int b = 0; b < STRB_WIDTH; b++) begin
      wr_word_s[8*b +: 8] = wr_strb_s[b] ? wr_data_s[8*b +: 8] : wr_word_s[8*b +: 8];
    end
    regs_d = regs_q;
    regs_d[addr_idx(wr_addr_s)] = (commit_s & wr_ok_s) ? wr_word_s : regs_q[addr_idx(wr_addr_s)];

    awaddr_d  = aw_hs_s ? s_axil_awaddr : awaddr_q;
    wdata_d   = w_hs_s ? s_axil_wdata : wdata_q;
    wstrb_d   = w_hs_s ? s_axil_wstrb : wstrb_q;
    aw_held_d = (bvalid_q & s_axil_bready) ? 1'b0 : (aw_held_q | aw_hs_s);
    w_held_d  = (bvalid_q & s_axil_bready) ? 1'b0 : (w_held_q | w_hs_s);
    bvalid_d  = commit_s ? 1'b1 : (bvalid_q & ~s_axil_bready);
    bresp_d   = commit_s ? (wr_ok_s ? 2'b00 : 2'b10) : bresp_q;

    // regs_q is sampled before this edge's commit, so a colliding read sees old data.
    rvalid_d  = ar_hs_s ? 1'b1 : (rvalid_q & ~s_axil_rready);
    rdata_d   = ar_hs_s ? (rd_ok_s ? regs_q[addr_idx(s_axil_araddr)] : {DATA_WIDTH{1'b0}}) : rdata_q;
    rresp_d   = ar_hs_s ? (rd_ok_s ? 2'b00 : 2'b10) : rresp_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= {DATA_WIDTH{1'b0}};
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q   <= {DATA_WIDTH{1'b0}};
      wstrb_q   <= {STRB_WIDTH{1'b0}};
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= {DATA_WIDTH{1'b0}};
      rresp_q   <= 2'b00;
    end else begin
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_regfile.sv
// Directed and randomized AXI-lite traffic against a word-array model of the register file.
module tb_axil_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] s_axil_awaddr = 16'h0;
  logic [2:0]  s_axil_awprot = 3'b0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = 32'h0;
  logic [3:0]  s_axil_wstrb = 4'h0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [15:0] s_axil_araddr = 16'h0;
  logic [2:0]  s_axil_arprot = 3'b0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] model [16];
  logic [31:0] rd_val;

  axil_regfile dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [15:0] a);
    return a[15:6] == 10'h0;
  endfunction

  // Drive AW after ca cycles and W after cw cycles; hold bready low for bdly cycles.
  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int ca, input int cw, input int bdly);
    bit aw_done = 0;
    bit w_done = 0;
    int cyc = 0;
    logic [1:0] exp_resp;
    exp_resp = in_range(addr) ? 2'b00 : 2'b10;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      if (aw_done) chk("awready_after_aw", s_axil_awready, 0);
      if (w_done)  chk("wready_after_w", s_axil_wready, 0);
      s_axil_awaddr  = addr;
      s_axil_wdata   = data;
      s_axil_wstrb   = strb;
      s_axil_awvalid = !aw_done && cyc >= ca;
      s_axil_wvalid  = !w_done && cyc >= cw;
      if (s_axil_awvalid && s_axil_awready) aw_done = 1;
      if (s_axil_wvalid && s_axil_wready) w_done = 1;
      cyc++;
    end
    if (!(aw_done && w_done)) chk("write_handshake_timeout", 0, 1);
    @(negedge clk);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    chk("bvalid_latency", s_axil_bvalid, 1);
    chk("bresp", s_axil_bresp, exp_resp);
    if (in_range(addr))
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr[5:2]][8*b +: 8] = data[8*b +: 8];
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      chk("bvalid_hold", s_axil_bvalid, 1);
      chk("bresp_hold", s_axil_bresp, exp_resp);
      chk("awready_during_b", s_axil_awready, 0);
      chk("wready_during_b", s_axil_wready, 0);
    end
    s_axil_bready = 1'b1;
    @(negedge clk);
    s_axil_bready = 1'b0;
    chk("bvalid_cleared", s_axil_bvalid, 0);
    chk("awready_after_b", s_axil_awready, 1);
    chk("wready_after_b", s_axil_wready, 1);
  endtask

  // Read one word, holding rready low for rdly cycles, and compare against the model.
  task automatic axi_read(input logic [15:0] addr, input int rdly, output logic [31:0] data);
    bit done = 0;
    int cyc = 0;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    exp_data = in_range(addr) ? model[addr[5:2]] : 32'h0;
    exp_resp = in_range(addr) ? 2'b00 : 2'b10;
    while (!done && cyc < 40) begin
      @(negedge clk);
      s_axil_araddr  = addr;
      s_axil_arvalid = 1'b1;
      if (s_axil_arready) done = 1;
      cyc++;
    end
    if (!done) chk("read_handshake_timeout", 0, 1);
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    chk("rvalid_latency", s_axil_rvalid, 1);
    chk("rdata", s_axil_rdata, exp_data);
    chk("rresp", s_axil_rresp, exp_resp);
    data = s_axil_rdata;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("rvalid_hold", s_axil_rvalid, 1);
      chk("rdata_hold", s_axil_rdata, exp_data);
      chk("arready_during_r", s_axil_arready, 0);
    end
    s_axil_rready = 1'b1;
    @(negedge clk);
    s_axil_rready = 1'b0;
    chk("rvalid_cleared", s_axil_rvalid, 0);
    chk("arready_after_r", s_axil_arready, 1);
  endtask

  initial begin
    logic [15:0] a;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    // Reset state
    #12;
    chk("rst_awready", s_axil_awready, 0);
    chk("rst_wready", s_axil_wready, 0);
    chk("rst_arready", s_axil_arready, 0);
    chk("rst_bvalid", s_axil_bvalid, 0);
    chk("rst_rvalid", s_axil_rvalid, 0);
    chk("rst_rdata", s_axil_rdata, 0);
    chk("rst_bresp", s_axil_bresp, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_awready", s_axil_awready, 1);
    chk("release_wready", s_axil_wready, 1);
    chk("release_arready", s_axil_arready, 1);

    // Aligned full write, AW and W together
    axi_write(16'h0004, 32'h12345678, 4'hF, 0, 0, 0);
    axi_read(16'h0004, 0, rd_val);
    chk("simple_readback", rd_val, 32'h12345678);

    // W three cycles ahead of AW with partial strobes
    axi_write(16'h0008, 32'h0, 4'hF, 0, 0, 0);
    axi_write(16'h0008, 32'hAABBCCDD, 4'h5, 3, 0, 0);
    axi_read(16'h0008, 0, rd_val);
    chk("strobe_readback", rd_val, 32'h00BB00DD);

    // Zero strobe commits nothing; unaligned low bits ignored
    axi_write(16'h0007, 32'hFFFFFFFF, 4'h0, 0, 2, 0);
    axi_read(16'h0005, 0, rd_val);

    // Out-of-range write and read, then whole-file comparison
    axi_write(16'h0040, 32'hDEADBEEF, 4'hF, 1, 0, 0);
    axi_read(16'h0040, 0, rd_val);
    for (int i = 0; i < 16; i++) axi_read(16'(i * 4), 0, rd_val);

    // Back-pressure on B and R
    axi_write(16'h0010, 32'hCAFEF00D, 4'hF, 0, 0, 5);
    axi_read(16'h0010, 5, rd_val);

    // Same-edge AR and commit to one word return the old value
    axi_write(16'h000C, 32'h1, 4'hF, 0, 0, 0);
    @(negedge clk);
    s_axil_awaddr = 16'h000C; s_axil_wdata = 32'h2; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    s_axil_araddr = 16'h000C; s_axil_arvalid = 1'b1;
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    chk("collide_bvalid", s_axil_bvalid, 1);
    chk("collide_rvalid", s_axil_rvalid, 1);
    chk("collide_old_data", s_axil_rdata, 32'h1);
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    @(negedge clk);
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    model[3] = 32'h2;
    axi_read(16'h000C, 0, rd_val);
    chk("collide_new_data", rd_val, 32'h2);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 7) == 0) ? (16'($urandom) | 16'h0040) : 16'($urandom_range(0, 63));
      axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2));
      a = ($urandom_range(0, 7) == 0) ? (16'($urandom) | 16'h0040) : 16'($urandom_range(0, 63));
      axi_read(a, $urandom_range(0, 2), rd_val);
    end

    // Reset with AW captured and W outstanding
    axi_write(16'h0000, 32'h0000FFFF, 4'hF, 0, 0, 0);
    @(negedge clk);
    s_axil_awaddr = 16'h0000; s_axil_awvalid = 1'b1;
    @(negedge clk);
    s_axil_awvalid = 1'b0;
    chk("pending_aw_held", s_axil_awready, 0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_awready", s_axil_awready, 0);
    chk("midrst_wready", s_axil_wready, 0);
    chk("midrst_bvalid", s_axil_bvalid, 0);
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_bvalid", s_axil_bvalid, 0);
      chk("post_rst_awready", s_axil_awready, 1);
    end
    axi_read(16'h0000, 0, rd_val);
    chk("post_rst_reg0", rd_val, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axil_regfile.md
AXIL_REGFILE -- requirements
Module: axil_regfile

Interface
REQ-001 SHALL implement the AXI-lite slave that consumes the AXI-lite bus driven by the test master: one clock; reset is asynchronous and active-low.
REQ-002 SHALL have these parameters:
- DATA_WIDTH, default 32, data bus width.
- ADDR_WIDTH, default 16, byte address width.
- STRB_WIDTH, default DATA_WIDTH/8, byte-lane count.
- REG_ADDR_WIDTH, default 4, log2 of register count.
REQ-003 SHALL have these ports (clock and reset first):
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-low.
- s_axil_awaddr  in  ADDR_WIDTH  write address.
- s_axil_awprot  in  3  accepted, ignored.
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address ready.
- s_axil_wdata  in  DATA_WIDTH  write data.
- s_axil_wstrb  in  STRB_WIDTH  byte enables.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data ready.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  write response ready.
- s_axil_araddr  in  ADDR_WIDTH  read address.
- s_axil_arprot  in  3  accepted, ignored.
- s_axil_arvalid  in  1  read address valid.
- s_axil_arready  out  1  read address ready.
- s_axil_rdata  out  DATA_WIDTH  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid  out  1  read data valid.
- s_axil_rready  in  1  read data ready.

Function
REQ-004 SHALL hold 2**REG_ADDR_WIDTH registers of DATA_WIDTH bits.
REQ-005 SHALL decode addresses as follows:
- Word index = addr[log2(STRB_WIDTH)+REG_ADDR_WIDTH-1 : log2(STRB_WIDTH)].
- Low log2(STRB_WIDTH) bits ignored (no unaligned error).
- Any nonzero bit above the index makes the address out of range.
REQ-006 SHALL capture AW and W independently:
- awready = !aw_held & !bvalid; wready = !w_held & !bvalid.
- Each channel is held after its handshake until the write commits.
REQ-007 SHALL commit the write on the edge where the second of AW/W is captured (same edge if both handshake together), and SHALL assert bvalid in the following cycle.
REQ-008 SHALL update only byte lanes whose wstrb bit is 1; wstrb=0 SHALL commit nothing but still return OKAY.
REQ-009 SHALL handle out-of-range writes: no register changes, bresp=SLVERR (2'b10); in-range writes give bresp=OKAY (2'b00).
REQ-010 SHALL hold bvalid and bresp stable until bready; on the bready&bvalid edge it SHALL clear aw_held/w_held, giving awready/wready high in the next cycle (max one write per 2 cycles).
REQ-011 SHALL drive arready = !rvalid.
REQ-012 SHALL sample the register on the AR handshake edge and present rvalid with rdata/rresp in the next cycle, stable until rready.
REQ-013 SHALL handle out-of-range reads: rdata=0, rresp=SLVERR; in-range reads give rresp=OKAY.
REQ-014 SHALL accept the next AR in the cycle after the R handshake (max one read per 2 cycles).
REQ-015 SHALL keep read and write paths independent and concurrent.
REQ-016 SHALL return pre-write data when an AR handshake and a write commit to the same word share an edge.
REQ-017 SHALL never drop or duplicate a handshake under any valid/ready pattern, including valid held across multiple cycles with ready low.

Reset
REQ-018 SHALL, while rst=0 (asynchronous assertion):
- clear all registers to 0 and clear aw_held, w_held, bvalid, rvalid.
- drive awready=wready=arready=0, bresp=rresp=0, rdata=0.
REQ-019 SHALL abandon any partially captured or pending transaction on reset mid-operation, with no register change and no B/R response afterwards.
REQ-020 SHALL release reset synchronously to clk, with awready/wready/arready high in the first cycle after deassertion.

Verification
REQ-021 Write 0x12345678 to 0x0004, wstrb=0xF, AW and W in the same cycle -> bvalid next cycle, bresp=0; read 0x0004 -> rdata=0x12345678, rresp=0.
REQ-022 W three cycles before AW, wdata=0xAABBCCDD, wstrb=0x5, to 0x0008 pre-loaded 0 -> wready low after the W handshake until B completes; read gives 0x00BB00DD.
REQ-023 Write to 0x0040 (out of range, REG_ADDR_WIDTH=4) -> bresp=2'b10, all 16 registers unchanged; read 0x0040 -> rdata=0, rresp=2'b10.
REQ-024 bready held low 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout; rready low 5 cycles -> rdata stable, arready=0.
REQ-025 Same-edge AR and write commit to 0x000C (old 0x1, new 0x2) -> read returns 0x1; a subsequent read returns 0x2.
REQ-026 Assert rst with AW held and W not yet sent -> after release no bvalid appears and register 0 reads 0.
